// File: rtl/dmem_responder_if.sv
// CPU data-memory request/response bus; master = CPU side, slave = memory side.
// DMEM_WSTRB_EN adds the per-byte store strobe req_wstrb.
interface dmem_responder_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
`ifdef DMEM_WSTRB_EN
    logic [DATA_W/8-1:0] req_wstrb;
`endif
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
`ifdef DMEM_WSTRB_EN
        output req_wstrb,
`endif
        output rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
`ifdef DMEM_WSTRB_EN
        input  req_wstrb,
`endif
        input  rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one word access at a time, fixed LATENCY to a held response.
// Optional byte-strobed stores when DMEM_WSTRB_EN is defined.
module dmem_responder #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic            clk,
    input  logic            rst,
    dmem_responder_if.slave bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_X  = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]      CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic              err_q, err_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              accept;
    logic              req_err;
    logic [IDX_W-1:0]  req_idx;
    logic              ld_we, ld_err;
    logic [IDX_W-1:0]  ld_idx;
    logic [DATA_W-1:0] ld_word;

    assign bus.req_ready = (state_q == IDLE) && !rst;
    assign accept        = bus.req_valid && bus.req_ready;
    // Full-width compare: out-of-range addresses must not alias into the array.
    assign req_err       = {1'b0, bus.req_addr} >= DEPTH_X;
    assign req_idx       = bus.req_addr[IDX_W-1:0];

    // Response data comes from the live request when LATENCY==1, else from the captured one.
    assign ld_we   = (state_q == IDLE) ? bus.req_we : we_q;
    assign ld_err  = (state_q == IDLE) ? req_err    : err_q;
    assign ld_idx  = (state_q == IDLE) ? req_idx    : idx_q;
    assign ld_word = (ld_we || ld_err) ? '0 : mem[ld_idx];

    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch is inferred.
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        err_d       = err_q;
        idx_d       = idx_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    we_d  = bus.req_we;
                    err_d = req_err;
                    idx_d = req_idx;
                    cnt_d = CNT_INIT;
                    if (LATENCY == 1) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = req_err;
                        rsp_rdata_d = ld_word;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = err_q;
                    rsp_rdata_d = ld_word;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop updates from pre-edge values.
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            idx_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            err_q       <= err_d;
            idx_q       <= idx_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // NOTE: the array has no reset so its contents survive rst and it maps onto RAM.
    always_ff @(posedge clk) begin
        if (accept && bus.req_we && !req_err) begin
`ifdef DMEM_WSTRB_EN
            for (int b = 0; b < DATA_W / 8; b++) begin
                if (bus.req_wstrb[b]) mem[req_idx][8*b +: 8] <= bus.req_wdata[8*b +: 8];
            end
`else
            mem[req_idx] <= bus.req_wdata;
`endif
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
endmodule
